rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one resource among eight requesters and drives the resource-select lines as a 3-bit index plus a one-hot decoded grant with enable, matching the decoder datapath it sequences. Sits between eight request sources and the shared resource; only one requester owns the resource at any time. Fairness comes from a rotating priority pointer, and a programmable hold limit guarantees forward progress.

---
 rtl/rr_arbiter8.sv | 123 ++++++++++++
 tb/tb_rr_arbiter8.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a rotating priority pointer and a
// programmable hold limit that forces the grant to rotate after MAX_HOLD cycles.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  // Handshake: a requester holds req[i] high while it wants the resource.
  // gnt[i] (with gnt_vld) means it owns the resource this cycle. The owner
  // ends its tenure with a one-cycle rel or by dropping req[i]. The hold
  // limit may also take the grant away, which is flagged by timeout.

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic HOLD_EN = (MAX_HOLD > 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  localparam logic IDLE  = 1'b0;
  localparam logic GRANT = 1'b1;

  logic          state, state_n;
  logic [2:0]    ptr, ptr_n;
  logic [2:0]    idx_n;
  logic [HW-1:0] hold, hold_n;
  logic          to_n;
  logic [7:0]    masked;
  logic [2:0]    w_req, w_mask;
  logic          owner_drop, hold_end;

  // First set bit of r, scanning upward from p and wrapping 7 -> 0.
  function automatic logic [2:0] find_first(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] res;
    logic       found;
    logic [2:0] cand;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cand = p + 3'(i);
      if (!found && r[cand]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign masked     = req & ~gnt;
  assign w_req      = find_first(req, ptr);
  assign w_mask     = find_first(masked, ptr);
  assign owner_drop = rel | ~req[gnt_idx];
  assign hold_end   = HOLD_EN && (hold == HOLD_LAST);

  always_comb begin
    state_n = state;
    idx_n   = gnt_idx;
    ptr_n   = ptr;
    hold_n  = hold;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        hold_n = '0;
        if (ena && (|req)) begin
          state_n = GRANT;
          idx_n   = w_req;
          ptr_n   = w_req + 3'd1;
        end
      end
      GRANT: begin
        if (!ena) begin
          state_n = IDLE;
          hold_n  = '0;
        end else if (owner_drop) begin
          // A release takes priority over a coincident timeout.
          hold_n = '0;
          if (|masked) begin
            idx_n = w_mask;
            ptr_n = w_mask + 3'd1;
          end else begin
            state_n = IDLE;
          end
        end else if (hold_end) begin
          // Owner stays eligible, so a lone requester is simply re-granted.
          to_n   = 1'b1;
          idx_n  = w_req;
          ptr_n  = w_req + 3'd1;
          hold_n = '0;
        end else begin
          hold_n = hold + HW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
      ptr     <= 3'd0;
      hold    <= '0;
    end else begin
      state   <= state_n;
      gnt_idx <= idx_n;
      gnt_vld <= (state_n == GRANT);
      gnt     <= (state_n == GRANT) ? (8'h01 << idx_n) : 8'h00;
      timeout <= to_n;
      ptr     <= ptr_n;
      hold    <= hold_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic, every cycle
// compared against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] req;
  logic       rel;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int total;
  int bad;

  // Model state: owner = -1 means nobody holds the resource.
  int m_owner;
  int m_ptr;
  int m_seen;
  int m_to;

  logic [12:0] exp_q[$];

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int search(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_seen  = 0;
    m_to    = 0;
  endtask

  task automatic grant_to(input int w);
    m_owner = w;
    m_ptr   = (w + 1) % 8;
    m_seen  = 1;
  endtask

  // One clock edge worth of arbitration rules.
  task automatic model_edge();
    int w;
    m_to = 0;
    if (m_owner < 0) begin
      m_seen = 0;
      if (ena && req != 8'h00) grant_to(search(req, m_ptr));
    end else if (!ena) begin
      m_owner = -1;
      m_seen  = 0;
    end else if (rel || !req[m_owner]) begin
      w = search(req & ~(8'h01 << m_owner), m_ptr);
      if (w >= 0) grant_to(w);
      else begin
        m_owner = -1;
        m_seen  = 0;
      end
    end else if (MH > 0 && m_seen == MH) begin
      m_to = 1;
      grant_to(search(req, m_ptr));
    end else begin
      m_seen++;
    end
  endtask

  task automatic step();
    logic [12:0] e;
    logic [7:0]  e_gnt;
    @(posedge clk);
    model_edge();
    e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
    exp_q.push_back({m_to[0], (m_owner >= 0), 3'(m_owner), e_gnt});
    #1;
    e = exp_q.pop_front();
    check("gnt", gnt, e[7:0]);
    check("gnt_vld", gnt_vld, e[11]);
    check("timeout", timeout, e[12]);
    if (e[11]) check("gnt_idx", gnt_idx, e[10:8]);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic reset_pulse();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 8'h00);
    check("rst_vld", gnt_vld, 1'b0);
    check("rst_to", timeout, 1'b0);
    check("rst_idx", gnt_idx, 3'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 8'hFF;
    rel   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("init_gnt", gnt, 8'h00);
    check("init_vld", gnt_vld, 1'b0);
    check("init_to", timeout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("first_gnt", gnt, 8'h01);
    check("first_idx", gnt_idx, 3'd0);

    // Rotation with a release every second cycle.
    for (int i = 0; i < 18; i++) begin
      rel = (i % 2 == 1);
      step();
    end
    rel = 1'b0;

    for (int i = 0; i < 20 && m_owner != 6; i++) begin
      rel = 1'b1;
      step();
    end
    rel = 1'b0;
    check("reach_idx6", gnt_idx, 3'd6);

    // Wrap and skip.
    req = 8'b0000_0101;
    rel = 1'b1;
    step();
    check("wrap_gnt", gnt, 8'h01);
    step();
    check("skip_gnt", gnt, 8'h04);
    rel = 1'b0;

    // Reset mid-grant, then the hold limit.
    req = 8'h0A;
    reset_pulse();
    step();
    check("to_first", gnt, 8'h02);
    repeat (3) step();
    check("to_held", gnt, 8'h02);
    step();
    check("to_rot_gnt", gnt, 8'h08);
    check("to_pulse", timeout, 1'b1);
    req = 8'h02;
    step();
    check("to_clear", timeout, 1'b0);
    repeat (12) step();
    check("solo_gnt", gnt, 8'h02);

    // Requester drop.
    req = 8'h08;
    step();
    check("drop_own3", gnt, 8'h08);
    req = 8'h00;
    step();
    check("drop_vld", gnt_vld, 1'b0);
    check("drop_gnt", gnt, 8'h00);

    // Enable off mid-grant, then resume from the retained pointer.
    req = 8'hFF;
    step();
    ena = 1'b0;
    step();
    check("ena_off_gnt", gnt, 8'h00);
    ena = 1'b1;
    step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: req = 8'(1 << $urandom_range(0, 7));
        1: req = 8'($urandom) & 8'($urandom);
        default: req = 8'($urandom);
      endcase
      rel = ($urandom_range(0, 3) == 0);
      ena = ($urandom_range(0, 9) != 0);
      step();
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
